inst_fetch_unit: RTL and testbench

Instruction fetch stage sitting between the 32-word instruction memory and the processor's instruction register. It generates instruction addresses, absorbs the memory's one-cycle read latency, and buffers prefetched 16-bit instruction words in a small FIFO. The words are handed to the processor over a valid/ready handshake, so the processor pulls one instruction per completed operation. A flush input redirects fetch to a new address and discards everything buffered or in flight.

---
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
//==============================================================================
// inst_fetch_unit
//   Instruction fetch stage: address generation, one-cycle memory latency
//   absorption and a small prefetch FIFO with a valid/ready output handshake.
//   Optional feature macro: IFU_WRAP_STOP_EN (stop fetch at top address).
// Revision: 1.0
//==============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd_en,
    input  logic [DATA_W-1:0]          mem_q,
    output logic [DATA_W-1:0]          instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       prog_end
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    c_DEPTH = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_TOP   = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [DATA_W-1:0] r_store [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_prog_end;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_need;
    logic [CNT_W:0]    w_limit;

    assign w_pop  = instr_valid && instr_ready;
    assign w_push = r_inflight;

    // A pop this cycle frees a slot, so the limit is raised by one instead
    // of subtracting from the occupancy (keeps the compare unsigned).
    assign w_need  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_limit = c_DEPTH + {{CNT_W{1'b0}}, w_pop};
    assign w_issue = !reset && !flush && !r_prog_end && (w_need < w_limit);

    assign mem_addr    = r_pc;
    assign mem_rd_en   = w_issue;
    assign instr       = r_store[r_rd_ptr];
    assign instr_valid = (r_count != '0);
    assign level       = r_count;
    assign prog_end    = r_prog_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_pc       <= flush_addr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
`ifdef IFU_WRAP_STOP_EN
                if (r_pc != c_TOP) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
`else
                r_pc <= r_pc + ADDR_W'(1);
`endif
            end
        end
    end

`ifdef IFU_WRAP_STOP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prog_end <= 1'b0;
        end else if (flush) begin
            r_prog_end <= 1'b0;
        end else if (w_issue && (r_pc == c_TOP)) begin
            r_prog_end <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prog_end <= 1'b0;
        end else begin
            r_prog_end <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is cleared on reset so instr reads zero until the first capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_store[i] <= '0;
            end
        end else if (!flush && w_push) begin
            r_store[r_wr_ptr] <= mem_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
//==============================================================================
// tb_inst_fetch_unit
//   Self-checking bench: directed scenarios plus randomized ready/flush traffic
//   compared every cycle against a queue-based transaction model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_q;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [4:0]  flush_addr;
    logic [2:0]  level;
    logic        prog_end;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: delivered-word queue, pending read, next fetch address.
    logic [15:0] mq[$];
    int          m_infl;
    logic [4:0]  m_infl_addr;
    logic [4:0]  m_pc;
    bit          m_end;

    inst_fetch_unit #(.ADDR_W(5), .DATA_W(16), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_q       (mem_q),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .level       (level),
        .prog_end    (prog_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [4:0] a);
        return 16'h1000 + {11'd0, a};
    endfunction

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) mem_q <= rom(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl      = 0;
        m_infl_addr = '0;
        m_pc        = '0;
        m_end       = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_level",   32'(level),       32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_instr",   32'(instr),       32'd0);
        chk("rst_addr",    32'(mem_addr),    32'd0);
        chk("rst_rd_en",   32'(mem_rd_en),   32'd0);
        chk("rst_prog_end",32'(prog_end),    32'd0);
    endtask

    // One clock cycle: drive at negedge, check before the edge, advance model.
    task automatic step(input logic rdy, input logic fl, input logic [4:0] fa);
        int pop;
        int rd;
        instr_ready = rdy;
        flush       = fl;
        flush_addr  = fa;
        #1;
        pop = (mq.size() > 0 && rdy) ? 1 : 0;
        rd  = (!fl && !m_end && (mq.size() - pop + m_infl < 4)) ? 1 : 0;
        chk("level",    32'(level),       32'(mq.size()));
        chk("valid",    32'(instr_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
        if (mq.size() > 0) chk("instr", 32'(instr), 32'(mq[0]));
        chk("mem_addr", 32'(mem_addr),    32'(m_pc));
        chk("rd_en",    32'(mem_rd_en),   32'(rd));
        chk("prog_end", 32'(prog_end),    32'(m_end));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_infl = 0;
            m_pc   = fa;
            m_end  = 0;
        end else begin
            if (pop != 0) void'(mq.pop_front());
            if (m_infl != 0) mq.push_back(rom(m_infl_addr));
            m_infl      = rd;
            m_infl_addr = m_pc;
            if (rd != 0) begin
`ifdef IFU_WRAP_STOP_EN
                if (m_pc == 5'd31) m_end = 1;
                else m_pc = m_pc + 5'd1;
`else
                m_pc = m_pc + 5'd1;
`endif
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        flush       = 1'b0;
        flush_addr  = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;

        // Streaming with the processor always ready.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 5'd0);

        // Backpressure: FIFO fills to DEPTH, then releases without loss.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0);
        chk("bp_level_full", 32'(level), 32'd4);
        chk("bp_rd_en_off",  32'(mem_rd_en), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd0);

        // Flush mid-stream after partial fill.
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd20);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd0);

        // Address wrap (or stop at the top address when enabled).
        step(1'b1, 1'b1, 5'd28);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 5'd0);
`ifdef IFU_WRAP_STOP_EN
        chk("wrap_prog_end", 32'(prog_end), 32'd1);
        chk("wrap_drained",  32'(level),    32'd0);
`endif

        // Flush coincident with a pop and a push.
        step(1'b1, 1'b1, 5'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd9);
        chk("flush_level_f1", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd0);

        // Asynchronous reset between clock edges with data buffered.
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd0);

        // Randomized ready and occasional flushes to arbitrary addresses.
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic f;
            logic [4:0] a;
            r = ($urandom_range(0, 99) < 65);
            f = ($urandom_range(0, 99) < 4);
            a = 5'($urandom);
            step(r, f, a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
